branch_predict_unit: RTL

- Parametrised dynamic branch predictor for the 5-stage pipeline: a direct-mapped branch target buffer with an N-bit saturating counter per entry.
- Replaces static predict-not-taken with flush on a branch resolved in MEM.
- Fetch queries it combinationally with the current PC to choose the next PC.
- The MEM stage reports each resolved branch; the block updates its table, flags a mispredict and supplies the redirect PC. It also keeps saturating statistics counters.

---
 rtl/bpu_if.sv | 30 +++
 rtl/branch_predict_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/bpu_if.sv
// Fetch lookup and MEM resolution bus between the pipeline and the branch predictor.
// The master drives PCs and resolved outcomes; the slave returns predictions and redirects.
interface bpu_if #(
  parameter int bPC   = 7,
  parameter int bSTAT = 16
);
  logic [bPC-1:0]   if_pc;
  logic             pred_taken;
  logic [bPC-1:0]   pred_target;
  logic             upd_valid;
  logic [bPC-1:0]   upd_pc;
  logic             upd_taken;
  logic [bPC-1:0]   upd_target;
  logic             upd_pred_taken;
  logic [bPC-1:0]   upd_pred_target;
  logic             mispredict;
  logic [bPC-1:0]   redirect_pc;
  logic [bSTAT-1:0] stat_branches;
  logic [bSTAT-1:0] stat_mispred;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, stat_branches, stat_mispred
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry saturating counters, combinational fetch lookup,
// MEM-stage update, mispredict/redirect generation and saturating statistics.
module branch_predict_unit #(
  parameter int bPC   = 7,
  parameter int bIDX  = 4,
  parameter int bCTR  = 2,
  parameter int bSTAT = 16
) (
  input logic  clock,
  input logic  reset,
  bpu_if.slave bus
);
  localparam int DEPTH = 1 << bIDX;
  localparam int bTAG  = bPC - bIDX - 2;
  localparam logic [bPC-1:0]   PC_STEP  = bPC'(4);
  localparam logic [bCTR-1:0]  CTR_MAX  = '1;
  localparam logic [bCTR-1:0]  CTR_WT   = bCTR'(1) << (bCTR - 1);
  localparam logic [bSTAT-1:0] STAT_MAX = '1;

  logic            valid_vec  [DEPTH];
  logic [bTAG-1:0] tag_vec    [DEPTH];
  logic [bPC-1:0]  target_vec [DEPTH];
  logic [bCTR-1:0] ctr_vec    [DEPTH];

  logic [bIDX-1:0] if_idx, upd_idx;
  logic [bTAG-1:0] if_tag, upd_tag;
  logic            if_hit, upd_hit;
  logic            wr_en;
  logic [bCTR-1:0] ctr_cur, ctr_d;
  logic [bPC-1:0]  target_d;

  // PC bits [1:0] are always zero for word-aligned instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

  assign if_idx  = bus.if_pc[bIDX+1:2];
  assign if_tag  = bus.if_pc[bPC-1:bIDX+2];
  assign upd_idx = bus.upd_pc[bIDX+1:2];
  assign upd_tag = bus.upd_pc[bPC-1:bIDX+2];

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign if_hit          = valid_vec[if_idx] && (tag_vec[if_idx] == if_tag);
  assign bus.pred_taken  = if_hit && ctr_vec[if_idx][bCTR-1];
  assign bus.pred_target = bus.pred_taken ? target_vec[if_idx] : bus.if_pc + PC_STEP;

  assign upd_hit = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);
  assign ctr_cur = ctr_vec[upd_idx];

  always_comb begin
    wr_en    = 1'b0;
    ctr_d    = ctr_cur;
    target_d = target_vec[upd_idx];
    if (bus.upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (bus.upd_taken) begin
          ctr_d    = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + bCTR'(1);
          target_d = bus.upd_target;
        end else begin
          ctr_d = (ctr_cur == '0) ? ctr_cur : ctr_cur - bCTR'(1);
        end
      end else if (bus.upd_taken) begin
        // Only taken branches earn an entry; they start weakly taken.
        wr_en    = 1'b1;
        ctr_d    = CTR_WT;
        target_d = bus.upd_target;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic            valid_q;
    logic [bTAG-1:0] tag_q;
    logic [bPC-1:0]  target_q;
    logic [bCTR-1:0] ctr_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q  <= 1'b0;
        tag_q    <= '0;
        target_q <= '0;
        ctr_q    <= '0;
      end else if (wr_en && (upd_idx == bIDX'(gi))) begin
        valid_q  <= 1'b1;
        tag_q    <= upd_tag;
        target_q <= target_d;
        ctr_q    <= ctr_d;
      end
    end

    assign valid_vec[gi]  = valid_q;
    assign tag_vec[gi]    = tag_q;
    assign target_vec[gi] = target_q;
    assign ctr_vec[gi]    = ctr_q;
  end

  assign bus.mispredict = bus.upd_valid &&
                          ((bus.upd_taken != bus.upd_pred_taken) ||
                           (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
  assign bus.redirect_pc = !bus.upd_valid ? '0 :
                           bus.upd_taken  ? bus.upd_target : bus.upd_pc + PC_STEP;

  logic [bSTAT-1:0] stat_br_q, stat_br_d;
  logic [bSTAT-1:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (bus.upd_valid) begin
      if (stat_br_q != STAT_MAX) stat_br_d = stat_br_q + bSTAT'(1);
      if (bus.mispredict && (stat_mp_q != STAT_MAX)) stat_mp_d = stat_mp_q + bSTAT'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign bus.stat_branches = stat_br_q;
  assign bus.stat_mispred  = stat_mp_q;
endmodule
